dense_stream_tx: RTL and testbench
==================================

Name: dense_stream_tx

Overview:
- Transmit-side feeder for the serial dense layer input stream: accepts one parallel activation vector of D signed DATA_WIDTH-bit elements and emits it one element at a time with a single-cycle valid strobe per element.
- Paces elements at one per GAP+1 cycles, because the dense consumer needs two cycles per element (capture, then kernel-ROM fetch and MAC).
- Sits between the flatten/pool stage and dense_int_rear.
- Two-entry vector buffer (ping-pong) hides the upstream hand-over while a vector is streaming.

Parameters:
- D, 64: elements per vector; must equal the consumer's D.
- DATA_WIDTH, 8: element width, signed two's complement.
- GAP, 1: idle cycles after every emitted element; GAP >= 1 (GAP = 0 is illegal).

Ports:
- clk  in  1  clock, all logic on posedge.
- rstn  in  1  synchronous reset, active-low.
- valid_i  in  1  upstream vector valid.
- data_i  in  D*DATA_WIDTH  vector; element k = data_i[k*DATA_WIDTH +: DATA_WIDTH].
- ready_o  out  1  buffer has a free bank.
- data_o  out  DATA_WIDTH  current element, signed.
- valid_o  out  1  one-cycle strobe per element.
- last_o  out  1  high with valid_o on element D-1 only.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rstn).
- Reset: valid_o=0, last_o=0, data_o=0, occupancy=0, element counter=0, gap counter=0, FSM=IDLE. ready_o=1 from the first cycle after reset. valid_i is ignored while rstn=0.
- ready_o is combinational: ready_o = (occupancy < 2).
- Accept: a vector is accepted when valid_i & ready_o are high at a posedge. It is written whole into the write bank; the write pointer toggles and occupancy increments.
- Once accepted, the vector is owned by the buffer; later changes on data_i have no effect.
- FSM:
  - IDLE: if occupancy > 0, load element 0 of the read bank into the output regs and go to EMIT.
  - EMIT: valid_o=1 for exactly one cycle. Then go to GAP, with gap counter = GAP.
  - GAP: valid_o=0 for GAP cycles. Then:
    - if elements remain, emit the next element;
    - else if occupancy > 0, emit element 0 of the next bank;
    - else go to IDLE.
- Timing:
  - With the block idle and empty, a vector accepted in cycle 0 gives element k on valid_o in cycle 2 + k*(GAP+1).
  - Spacing between consecutive valid_o pulses is always exactly GAP+1 cycles, including across a vector boundary when the next bank is already full.
- Element counter: clogb2(D-1) bits, wraps D-1 -> 0. last_o = valid_o & (count == D-1).
- Bank free: the read bank is freed at the posedge ending the cycle that carries last_o; the read pointer toggles.
  - Free and accept on the same edge (occupancy 1): occupancy stays 1, and the two banks stay distinct.
  - With occupancy 2, ready_o=0, so an accept cannot coincide with a full buffer.
- data_o holds the last emitted value while valid_o=0. Elements pass through bit-exact; no arithmetic and no saturation.
- Reset mid-stream: any in-flight and buffered vectors are discarded. The next vector after reset starts at element 0.
- Integration: data_o and valid_o connect directly to the dense layer's data_i and valid_i. The dense layer produces exactly one result per D emitted elements, i.e. per vector.

Test Plan:
- Single vector (D=4, GAP=1): vector {04,03,02,01} (element 0 = 01) accepted in cycle 0 -> valid_o in cycles 2, 4, 6, 8 with data 01, 02, 03, 04; last_o only in cycle 8; valid_o=0 in all other cycles.
- Back-to-back (D=4, GAP=1): valid_i held with vectors A, B, C -> A accepted in cycle 0, B in cycle 1; ready_o=0 from cycle 2 to cycle 8; C accepted in cycle 9; B elements in cycles 10, 12, 14, 16; C elements in cycles 18, 20, 22, 24.
- Signed pass-through: elements 80, 7F, FF, 00 -> emitted unchanged in order; last_o on 00.
- Reset mid-stream (D=4, GAP=1): rstn=0 in cycle 5 -> valid_o=0 and ready_o=1 from cycle 6 on, no further pulses. A new vector accepted afterwards starts at element 0 with the idle latency of 2 cycles.
- GAP=3, D=4: vector accepted in cycle 0 -> valid_o in cycles 2, 6, 10, 14; a second buffered vector starts in cycle 18.
- Integration (D=64, B=7, DATA_WIDTH=8) with the dense layer and known kernel/bias files, two vectors -> dense valid_o pulses exactly twice, once after each vector's last element is consumed; outputs match the golden int model, saturated to [-128, 127].

Source files
------------

// File: rtl/dense_stream_tx.sv
// Feeds the serial dense layer: buffers whole activation vectors in two banks and
// streams them out one element per GAP+1 cycles with a single-cycle valid strobe.
module dense_stream_tx #(
   parameter int D          = 64,
   parameter int DATA_WIDTH = 8,
   parameter int GAP        = 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         valid_i,
   input  logic [D*DATA_WIDTH-1:0]      data_i,
   output logic                         ready_o,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic                         valid_o,
   output logic                         last_o,
   output logic [1:0]                   dbg_state
);

   // Handshake: a vector moves on a posedge where valid_i & ready_o are both high;
   // ready_o depends only on buffer occupancy, never on valid_i.

   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(D - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [D*DATA_WIDTH-1:0] bank [2];
   logic                    wr_ptr, rd_ptr;
   logic [1:0]              occ;
   logic [CW-1:0]           count;
   logic [GW-1:0]           gap_cnt, gap_nxt;
   logic                    load, load_first;
   logic [CW-1:0]           elem_idx;
   logic [DATA_WIDTH-1:0]   elem;
   logic                    accept, free;

   assign ready_o   = (occ < 2'd2);
   assign accept    = valid_i & ready_o;
   assign last_o    = valid_o & (count == LAST_IDX);
   // The read bank is released on the edge that ends its last element's strobe.
   assign free      = last_o;
   assign dbg_state = state;

   assign elem_idx = load_first ? '0 : count + CW'(1);
   assign elem     = bank[rd_ptr][elem_idx*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_nxt  = state;
      gap_nxt    = gap_cnt;
      load       = 1'b0;
      load_first = 1'b0;
      case (state)
         S_IDLE: begin
            if (occ != 2'd0) begin
               load       = 1'b1;
               load_first = 1'b1;
               state_nxt  = S_EMIT;
            end
         end
         S_EMIT: begin
            state_nxt = S_GAP;
            gap_nxt   = GW'(GAP);
         end
         S_GAP: begin
            if (gap_cnt == GW'(1)) begin
               if (count != LAST_IDX) begin
                  load      = 1'b1;
                  state_nxt = S_EMIT;
               end else if (occ != 2'd0) begin
                  // occ and rd_ptr already reflect the bank freed after the last strobe
                  load       = 1'b1;
                  load_first = 1'b1;
                  state_nxt  = S_EMIT;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               gap_nxt = gap_cnt - GW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= S_IDLE;
         gap_cnt <= '0;
         count   <= '0;
         valid_o <= 1'b0;
         data_o  <= '0;
         occ     <= 2'd0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_nxt;
         valid_o <= load;
         if (load) begin
            data_o <= elem;
            count  <= elem_idx;
         end
         if (accept) wr_ptr <= ~wr_ptr;
         if (free)   rd_ptr <= ~rd_ptr;
         case ({accept, free})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Vector storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (rstn && accept) bank[wr_ptr] <= data_i;
   end

endmodule

// File: tb/tb_dense_stream_tx.sv
// Directed bench for dense_stream_tx (D=4): GAP=1 and GAP=3 instances, element/last
// and strobe-cycle scoreboard built from the vector acceptance cycles.
module tb_dense_stream_tx;

   localparam int D  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rstn;
   logic            valid_i, valid_i3;
   logic [D*DW-1:0] data_i, data_i3;
   logic            ready_o, ready_o3;
   logic [DW-1:0]   data_o, data_o3;
   logic            valid_o, valid_o3;
   logic            last_o, last_o3;
   logic [1:0]      dbg_state, dbg_state3;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW:0] exp_q[$];
   int          exp_cyc_q[$];
   int          prev_last = -1000;
   logic [DW:0] exp3_q[$];
   int          exp3_cyc_q[$];
   int          prev_last3 = -1000;

   dense_stream_tx #(.D(D), .DATA_WIDTH(DW), .GAP(1)) dut (
      .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i),
      .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
      .dbg_state(dbg_state)
   );

   dense_stream_tx #(.D(D), .DATA_WIDTH(DW), .GAP(3)) dut3 (
      .clk(clk), .rstn(rstn), .valid_i(valid_i3), .data_i(data_i3),
      .ready_o(ready_o3), .data_o(data_o3), .valid_o(valid_o3), .last_o(last_o3),
      .dbg_state(dbg_state3)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [D*DW-1:0] mk(input logic [7:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   // Expected schedule: first element two cycles after acceptance, or GAP+1 after
   // the previous vector's last element, whichever is later.
   task automatic push_model(input logic [D*DW-1:0] v, input int acc, input int g, input bit third);
      int start;
      logic [D*DW-1:0] vv;
      vv = v;
      if (!third) start = (acc + 2 > prev_last + g + 1) ? acc + 2 : prev_last + g + 1;
      else        start = (acc + 2 > prev_last3 + g + 1) ? acc + 2 : prev_last3 + g + 1;
      for (int k = 0; k < D; k++) begin
         if (!third) begin
            exp_q.push_back({(k == D - 1), vv[k*DW +: DW]});
            exp_cyc_q.push_back(start + k * (g + 1));
         end else begin
            exp3_q.push_back({(k == D - 1), vv[k*DW +: DW]});
            exp3_cyc_q.push_back(start + k * (g + 1));
         end
      end
      if (!third) prev_last  = start + (D - 1) * (g + 1);
      else        prev_last3 = start + (D - 1) * (g + 1);
   endtask

   // driver tasks: called at a negedge, return at the negedge after acceptance
   task automatic send_vec(input logic [D*DW-1:0] v, output int acc, output int stalls);
      valid_i = 1'b1;
      data_i  = v;
      stalls  = 0;
      acc     = -1;
      for (int i = 0; i < 100; i++) begin
         if (ready_o) begin
            acc = cyc;
            break;
         end
         stalls++;
         @(negedge clk);
      end
      if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
      else push_model(v, acc, 1, 1'b0);
      @(negedge clk);
   endtask

   task automatic send_vec3(input logic [D*DW-1:0] v, output int acc);
      valid_i3 = 1'b1;
      data_i3  = v;
      acc      = -1;
      for (int i = 0; i < 100; i++) begin
         if (ready_o3) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) chk("accept3_timeout", 32'd0, 32'd1);
      else push_model(v, acc, 3, 1'b1);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && exp3_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_timeout", 32'(exp_q.size() + exp3_q.size()), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   // scoreboards
   always @(negedge clk) begin
      if (valid_o) begin
         if (exp_q.size() == 0) chk("unexpected_pulse", {31'd0, valid_o}, 32'd0);
         else begin
            chk("elem_last", {23'd0, last_o, data_o}, {23'd0, exp_q.pop_front()});
            chk("pulse_cycle", cyc, exp_cyc_q.pop_front());
         end
      end else if (last_o) begin
         chk("last_without_valid", {31'd0, last_o}, 32'd0);
      end
   end

   always @(negedge clk) begin
      if (valid_o3) begin
         if (exp3_q.size() == 0) chk("unexpected_pulse3", {31'd0, valid_o3}, 32'd0);
         else begin
            chk("elem_last3", {23'd0, last_o3, data_o3}, {23'd0, exp3_q.pop_front()});
            chk("pulse_cycle3", cyc, exp3_cyc_q.pop_front());
         end
      end
   end

   initial begin
      int a0, a1, a2, s0, s1, s2, t0;
      rstn = 1'b0; valid_i = 1'b0; data_i = '0; valid_i3 = 1'b0; data_i3 = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_last", {31'd0, last_o}, 32'd0);
      chk("rst_data", {24'd0, data_o}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
      chk("ready3_after_rst", {31'd0, ready_o3}, 32'd1);

      // single vector, data_i scrambled right after acceptance
      send_vec(mk(8'h01, 8'h02, 8'h03, 8'h04), a0, s0);
      valid_i = 1'b0;
      data_i  = $urandom;
      drain();

      // back-to-back A, B, C with valid_i held
      send_vec(mk(8'h11, 8'h12, 8'h13, 8'h14), a0, s0);
      send_vec(mk(8'h21, 8'h22, 8'h23, 8'h24), a1, s1);
      send_vec(mk(8'h31, 8'h32, 8'h33, 8'h34), a2, s2);
      valid_i = 1'b0;
      data_i  = $urandom;
      chk("b_accept_cycle", a1 - a0, 32'd1);
      chk("c_accept_cycle", a2 - a0, 32'd9);
      chk("c_stall_cycles", s2, 32'd7);
      drain();

      // signed extremes pass through bit-exact
      send_vec(mk(8'h80, 8'h7F, 8'hFF, 8'h00), a0, s0);
      valid_i = 1'b0;
      drain();

      // reset in cycle 5 of a stream
      send_vec(mk(8'h41, 8'h42, 8'h43, 8'h44), t0, s0);
      valid_i = 1'b0;
      while (cyc < t0 + 5) @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      exp_q.delete();
      exp_cyc_q.delete();
      prev_last = -1000;
      @(negedge clk);
      chk("midrst_valid", {31'd0, valid_o}, 32'd0);
      chk("midrst_ready", {31'd0, ready_o}, 32'd1);
      chk("midrst_data", {24'd0, data_o}, 32'd0);
      rstn = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_quiet", {31'd0, valid_o}, 32'd0);
      end
      send_vec(mk(8'h51, 8'h52, 8'h53, 8'h54), a0, s0);
      valid_i = 1'b0;
      drain();

      // random vectors with random idle gaps
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(0, 12)) @(negedge clk);
         send_vec($urandom, a0, s0);
         valid_i = 1'b0;
         data_i  = $urandom;
      end
      drain();

      // GAP=3 instance, two buffered vectors
      send_vec3(mk(8'hA1, 8'hA2, 8'hA3, 8'hA4), a0);
      send_vec3(mk(8'hB1, 8'hB2, 8'hB3, 8'hB4), a1);
      valid_i3 = 1'b0;
      data_i3  = $urandom;
      chk("gap3_second_accept", a1 - a0, 32'd1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
